// File: rtl/cg_window_pkg.sv
// Shared constants, op codes and state encoding for the clock-gated window engine.
package cg_window_pkg;

    localparam int DW     = 7;
    localparam int IMG    = 8;
    localparam int WIN    = 4;
    localparam int NOP    = 15;
    localparam int NPIX   = IMG * IMG;
    localparam int NWIN   = WIN * WIN;
    localparam int MAXORG = IMG - WIN;

    localparam int LCW = 6;
    localparam int ECW = 4;

    localparam logic [3:0] OP_UP     = 4'd0;
    localparam logic [3:0] OP_DOWN   = 4'd1;
    localparam logic [3:0] OP_LEFT   = 4'd2;
    localparam logic [3:0] OP_RIGHT  = 4'd3;
    localparam logic [3:0] OP_NEG    = 4'd4;
    localparam logic [3:0] OP_ROTCW  = 4'd5;
    localparam logic [3:0] OP_ROTCCW = 4'd6;
    localparam logic [3:0] OP_MIRROR = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Two's complement negation that maps the most negative value onto the most positive one.
    function automatic logic signed [DW-1:0] negSat(input logic signed [DW-1:0] x);
        if (x == {1'b1, {(DW-1){1'b0}}}) begin
            return {1'b0, {(DW-1){1'b1}}};
        end
        return -x;
    endfunction

endpackage

// File: rtl/cg_window_engine_clk_gate.sv
// Latch-based integrated clock gate: the enable is captured while the clock is low so the gated clock never glitches.
module cg_clk_gate (
    input  logic i_clk,
    input  logic i_en,
    output logic o_gclk
);

    logic r_enLatch;

    // Transparent while the clock is low, holds through the high phase.
    always_latch begin
        if (!i_clk) begin
            r_enLatch <= i_en;
        end
    end

    assign o_gclk = i_clk & r_enLatch;

endmodule

// File: rtl/cg_window_engine.sv
// Loads an 8x8 signed image and 15 op codes, runs the ops on a sliding 4x4 window and streams the window out.
module cg_window_engine
    import cg_window_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cg_en,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    input  logic [3:0]           op,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data
);

    state_t r_state;
    state_t w_nextState;

    logic [LCW-1:0] r_loadCnt;
    logic [ECW-1:0] r_execCnt;
    logic [ECW-1:0] r_outCnt;
    logic [2:0]     r_orgRow;
    logic [2:0]     r_orgCol;
    logic           r_outTail;

    logic signed [DW-1:0] r_img [NPIX];
    logic [3:0]           r_ops [NOP];

    logic                 w_imgEn;
    logic                 w_outEn;
    logic                 w_imgClk;
    logic                 w_outClk;
    logic [3:0]           w_curOp;
    logic                 w_winWrite;
    logic [LCW-1:0]       w_winIdx [NWIN];
    logic signed [DW-1:0] w_win    [NWIN];
    logic signed [DW-1:0] w_newWin [NWIN];

    // Image bank runs while loading or executing, plus the edge that captures pixel 0 out of IDLE.
    assign w_imgEn = !cg_en || (r_state == LOAD) || (r_state == EXEC) || ((r_state == IDLE) && in_valid);
    // Output registers run while streaming and for one more edge to clear back to zero.
    assign w_outEn = !cg_en || (r_state == OUT) || r_outTail;

    cg_clk_gate u_imgGate (
        .i_clk  (clk),
        .i_en   (w_imgEn),
        .o_gclk (w_imgClk)
    );

    cg_clk_gate u_outGate (
        .i_clk  (clk),
        .i_en   (w_outEn),
        .o_gclk (w_outClk)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Phase sequencing: each phase ends on its own counter reaching its last value.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (in_valid) w_nextState = LOAD;
            LOAD: if (in_valid && (r_loadCnt == LCW'(NPIX - 1))) w_nextState = EXEC;
            EXEC: if (r_execCnt == ECW'(NOP - 1)) w_nextState = OUT;
            OUT:  if (r_outCnt == ECW'(NWIN - 1)) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign w_curOp    = r_ops[r_execCnt];
    assign w_winWrite = (r_state == EXEC) && (w_curOp >= OP_NEG) && (w_curOp <= OP_MIRROR);

    // Phase counters and window origin; the origin restarts at (0,0) whenever a new pattern begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loadCnt <= '0;
            r_execCnt <= '0;
            r_outCnt  <= '0;
            r_orgRow  <= '0;
            r_orgCol  <= '0;
            r_outTail <= 1'b0;
        end else begin
            r_outTail <= (r_state == OUT);
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_loadCnt <= LCW'(1);
                        r_execCnt <= '0;
                        r_outCnt  <= '0;
                        r_orgRow  <= '0;
                        r_orgCol  <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        r_loadCnt <= r_loadCnt + LCW'(1);
                    end
                end
                EXEC: begin
                    r_execCnt <= (r_execCnt == ECW'(NOP - 1)) ? '0 : r_execCnt + ECW'(1);
                    case (w_curOp)
                        OP_UP:    if (r_orgRow != 3'd0)         r_orgRow <= r_orgRow - 3'd1;
                        OP_DOWN:  if (r_orgRow < 3'(MAXORG))    r_orgRow <= r_orgRow + 3'd1;
                        OP_LEFT:  if (r_orgCol != 3'd0)         r_orgCol <= r_orgCol - 3'd1;
                        OP_RIGHT: if (r_orgCol < 3'(MAXORG))    r_orgCol <= r_orgCol + 3'd1;
                        default: ;
                    endcase
                end
                OUT: begin
                    r_outCnt <= (r_outCnt == ECW'(NWIN - 1)) ? '0 : r_outCnt + ECW'(1);
                end
                default: ;
            endcase
        end
    end

    // Current window view of the image and its transformed version for the op being executed.
    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                w_winIdx[r*WIN+c] = {r_orgRow + 3'(r), r_orgCol + 3'(c)};
                w_win[r*WIN+c]    = r_img[{r_orgRow + 3'(r), r_orgCol + 3'(c)}];
            end
        end
        for (int i = 0; i < NWIN; i++) begin
            w_newWin[i] = w_win[i];
        end
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                case (w_curOp)
                    OP_NEG:    w_newWin[r*WIN+c] = negSat(w_win[r*WIN+c]);
                    OP_ROTCW:  w_newWin[r*WIN+c] = w_win[(WIN-1-c)*WIN+r];
                    OP_ROTCCW: w_newWin[r*WIN+c] = w_win[c*WIN+(WIN-1-r)];
                    OP_MIRROR: w_newWin[r*WIN+c] = w_win[r*WIN+(WIN-1-c)];
                    default: ;
                endcase
            end
        end
    end

    // Image and op storage: filled during load, window ops write their result back in place.
    always_ff @(posedge w_imgClk) begin
        if ((r_state == IDLE) && in_valid) begin
            r_img[0] <= in_data;
            r_ops[0] <= op;
        end else if ((r_state == LOAD) && in_valid) begin
            r_img[r_loadCnt] <= in_data;
            if (r_loadCnt < LCW'(NOP)) begin
                r_ops[r_loadCnt[3:0]] <= op;
            end
        end else if (w_winWrite) begin
            for (int i = 0; i < NWIN; i++) begin
                r_img[w_winIdx[i]] <= w_newWin[i];
            end
        end
    end

    // Registered output stream; zero whenever not streaming.
    always_ff @(posedge w_outClk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (r_state == OUT) begin
            out_valid <= 1'b1;
            out_data  <= w_win[r_outCnt];
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end
    end

endmodule
